fcs_gen_8: RTL and testbench
============================

Name: fcs_gen_8

Overview:
Transmit-side Ethernet FCS generator for the byte-wide MAC datapath. It is the counterpart of the receive CRC-32 checker. It accepts frame bytes (destination MAC through payload) on a valid/ready stream and passes them through. Frames shorter than a minimum length are zero-padded, and the 4-byte FCS is appended. Output feeds the MII nibble transmitter.

Parameters:
P_MIN_LEN, 60, minimum pre-FCS frame length in bytes; short frames are zero-padded to this length; 0 disables padding.
P_CNT_W, 6, width of the saturating byte counter; must satisfy 2^P_CNT_W > P_MIN_LEN.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
s_data  in  8  input frame byte
s_vld  in  1  s_data valid
s_last  in  1  s_data is the final byte of the frame
s_rdy  out  1  block accepts s_data this cycle
m_data  out  8  output byte (data, pad or FCS)
m_vld  out  1  m_data valid
m_last  out  1  m_data is the final FCS byte
m_rdy  in  1  downstream accepts m_data

Behaviour:
- Clock clk; reset rst_n is synchronous and active-low.
- Reset values: m_vld=0, m_last=0, m_data=0, s_rdy=0, state=ST_DATA, crc=32'hFFFFFFFF, count=0, fcs_idx=0.
- Output register stage:
  - adv = ~m_vld | m_rdy.
  - Output regs load only when adv=1.
  - If adv=1 and nothing is produced, m_vld clears.
  - m_data/m_last hold while m_vld=1 and m_rdy=0.
- CRC:
  - Polynomial 0x04C11DB7, init all-ones.
  - Input byte is bit-reversed before entering the LFSR (data[i]=byte[7-i]).
  - Next-state equations are identical to the receive checker's.
  - Updated on every byte emitted in ST_DATA and ST_PAD.
- FCS byte k (k=0..3, sent in order) = bit-reverse of ~crc[31-8k -: 8], taken from the final CRC.
- count: saturating byte counter; increments per data or pad byte emitted; stops at P_MIN_LEN.
- ST_DATA:
  - s_rdy = adv.
  - On s_vld&s_rdy: m_data=s_data, m_vld=1, m_last=0; crc and count update.
  - If s_last and count+1 < P_MIN_LEN, go to ST_PAD; else go to ST_FCS with fcs_idx=0.
- ST_PAD:
  - s_rdy=0.
  - On adv: emit 0x00, update crc and count.
  - When the emitted byte brings count to P_MIN_LEN, go to ST_FCS.
- ST_FCS:
  - s_rdy=0.
  - On adv: emit FCS byte fcs_idx, then increment fcs_idx.
  - fcs_idx=3: m_last=1; crc<=all-ones, count<=0; go to ST_DATA.
- Latency: 1 cycle from input acceptance to m_vld. No bubbles under continuous m_rdy=1, so frames run back-to-back. The first byte of the next frame may be accepted the cycle after the last FCS byte is loaded.
- Minimum frame: a single-byte frame with s_last is valid.
- s_last without any prior byte is impossible by construction.
- s_vld with s_rdy=0: the input holds; no byte is lost or duplicated.
- Reset mid-frame: the frame is abandoned and all state returns to reset values. The downstream sees m_vld drop with no m_last; the downstream must discard the partial frame.
- Upstream must not deassert s_vld mid-frame. If it does, the block simply waits; no timeout.

Decomposition:
- Package crc32_pkg:
  - CRC32_INIT = 32'hFFFFFFFF
  - CRC32_RESIDUE = 32'hC704DD7B
  - function crc32_byte_next(crc[31:0], byte[7:0]), including the bit reversal
  - function bitrev8
  - typedef enum fcs_state_t {ST_DATA, ST_PAD, ST_FCS}
- The checker is migrated to the same package function, so both directions share one set of equations.
- No sub-module; the CRC step is the package function.

Test Plan:
1. P_MIN_LEN=0, ASCII "123456789" (0x31..0x39), m_rdy=1 -> output 0x31..0x39 then 0x26,0x39,0xF4,0xCB; m_last only on 0xCB; first m_vld 1 cycle after first accept.
2. P_MIN_LEN=60, one byte 0xAA -> 0xAA + 59×0x00 + 4 FCS bytes (64 total), s_rdy=0 throughout pad/FCS. Feed the result through the receive checker -> crc_vld pulses exactly on the 64th byte.
3. Random m_rdy backpressure (50%) on a 100-byte random frame -> output byte stream identical to the m_rdy=1 run; m_data stable while m_vld&~m_rdy; no drops.
4. Three back-to-back frames of 60, 61 and 1 bytes with s_vld held high -> no idle cycles on m_vld; each FCS independently correct (CRC re-initialised); no padding on the 60/61-byte frames.
5. Assert rst_n=0 for 1 cycle during FCS byte 2 -> next cycle m_vld=0, s_rdy=0. The following frame "123456789" with P_MIN_LEN=0 -> FCS 0x26,0x39,0xF4,0xCB.
6. Frame exactly 59 bytes, P_MIN_LEN=60 -> exactly one 0x00 pad byte, then FCS; total 64 output bytes.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared Ethernet CRC-32 definitions used by both the transmit FCS generator
// and the receive checker, so the two directions run one set of equations.
package crc32_pkg;

  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAD  = 2'd1,
    ST_FCS  = 2'd2
  } fcs_state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  // Ethernet sends each byte LSB first, so the byte is reversed and then
  // shifted MSB-first through the non-reflected LFSR.
  function automatic logic [31:0] crc32_byte_next(input logic [31:0] crc,
                                                  input logic [7:0]  data_byte);
    logic [7:0]  d;
    logic [31:0] c;
    logic        fb;
    d = bitrev8(data_byte);
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) begin
        c = c ^ CRC32_POLY;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/fcs_gen_8.sv
// Transmit-side Ethernet FCS generator: passes frame bytes through, zero-pads
// short frames to P_MIN_LEN and appends the 4-byte FCS behind one output register.
module fcs_gen_8
  import crc32_pkg::*;
#(
  parameter int P_MIN_LEN = 60,
  parameter int P_CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_vld,
  input  logic       s_last,
  output logic       s_rdy,
  output logic [7:0] m_data,
  output logic       m_vld,
  output logic       m_last,
  input  logic       m_rdy
);

  // Stream handshake (both sides): a byte moves on a rising clk edge where
  // vld and rdy are both high; a source holds its data and vld until then.

  localparam logic [P_CNT_W-1:0] MIN_C = P_CNT_W'(P_MIN_LEN);
  localparam logic [P_CNT_W-1:0] ONE_C = P_CNT_W'(1);

  fcs_state_t         state_q, state_d;
  logic [31:0]        crc_q, crc_d;
  logic [P_CNT_W-1:0] count_q, count_d;
  logic [1:0]         fcs_idx_q, fcs_idx_d;
  logic [7:0]         m_data_q, m_data_d;
  logic               m_vld_q, m_vld_d;
  logic               m_last_q, m_last_d;
  logic               rdy_en_q, rdy_en_d;

  logic               adv;
  logic [P_CNT_W-1:0] count_inc;
  logic [31:0]        crc_inv;
  logic [7:0]         fcs_byte;

  assign adv = ~m_vld_q | m_rdy;

  // rdy_en_q keeps s_rdy low for the first cycle out of reset.
  assign s_rdy = rdy_en_q & (state_q == ST_DATA) & adv;

  assign m_data = m_data_q;
  assign m_vld  = m_vld_q;
  assign m_last = m_last_q;

  always_comb begin
    count_inc = (count_q == MIN_C) ? count_q : count_q + ONE_C;
    crc_inv   = ~crc_q;
    case (fcs_idx_q)
      2'd0:    fcs_byte = bitrev8(crc_inv[31:24]);
      2'd1:    fcs_byte = bitrev8(crc_inv[23:16]);
      2'd2:    fcs_byte = bitrev8(crc_inv[15:8]);
      default: fcs_byte = bitrev8(crc_inv[7:0]);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    count_d   = count_q;
    fcs_idx_d = fcs_idx_q;
    m_data_d  = m_data_q;
    m_vld_d   = m_vld_q;
    m_last_d  = m_last_q;
    rdy_en_d  = 1'b1;

    if (adv) begin
      m_vld_d  = 1'b0;
      m_last_d = 1'b0;
    end

    case (state_q)
      ST_DATA: begin
        if (s_vld && s_rdy) begin
          m_data_d = s_data;
          m_vld_d  = 1'b1;
          crc_d    = crc32_byte_next(crc_q, s_data);
          count_d  = count_inc;
          if (s_last) begin
            if (count_inc < MIN_C) begin
              state_d = ST_PAD;
            end else begin
              state_d   = ST_FCS;
              fcs_idx_d = 2'd0;
            end
          end
        end
      end

      ST_PAD: begin
        if (adv) begin
          m_data_d = 8'h00;
          m_vld_d  = 1'b1;
          crc_d    = crc32_byte_next(crc_q, 8'h00);
          count_d  = count_inc;
          if (count_inc == MIN_C) begin
            state_d   = ST_FCS;
            fcs_idx_d = 2'd0;
          end
        end
      end

      ST_FCS: begin
        if (adv) begin
          m_data_d  = fcs_byte;
          m_vld_d   = 1'b1;
          fcs_idx_d = fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) begin
            m_last_d = 1'b1;
            crc_d    = CRC32_INIT;
            count_d  = '0;
            state_d  = ST_DATA;
          end
        end
      end

      default: begin
        state_d = ST_DATA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_DATA;
      crc_q     <= CRC32_INIT;
      count_q   <= '0;
      fcs_idx_q <= 2'd0;
      m_data_q  <= 8'h00;
      m_vld_q   <= 1'b0;
      m_last_q  <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      count_q   <= count_d;
      fcs_idx_q <= fcs_idx_d;
      m_data_q  <= m_data_d;
      m_vld_q   <= m_vld_d;
      m_last_q  <= m_last_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_fcs_gen_8.sv
// Bench for fcs_gen_8: one instance without padding and one padding to 60 bytes,
// checked against a reflected (LSB-first) CRC-32 reference and a byte scoreboard.
module tb_fcs_gen_8;

  localparam int PAT_ASCII = 0;
  localparam int PAT_AA    = 1;
  localparam int PAT_RAND  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_vld = 1'b0;
  logic       s_last = 1'b0;
  logic       m_rdy = 1'b1;
  logic       sel = 1'b1;

  logic       s_vld0, m_rdy0, s_rdy0, m_vld0, m_last0;
  logic [7:0] m_data0;
  logic       s_vld1, m_rdy1, s_rdy1, m_vld1, m_last1;
  logic [7:0] m_data1;
  logic       s_rdy, m_vld, m_last;
  logic [7:0] m_data;

  assign s_vld0 = s_vld & ~sel;
  assign m_rdy0 = m_rdy | sel;
  assign s_vld1 = s_vld & sel;
  assign m_rdy1 = m_rdy | ~sel;
  assign s_rdy  = sel ? s_rdy1  : s_rdy0;
  assign m_vld  = sel ? m_vld1  : m_vld0;
  assign m_last = sel ? m_last1 : m_last0;
  assign m_data = sel ? m_data1 : m_data0;

  fcs_gen_8 #(.P_MIN_LEN(0), .P_CNT_W(6)) u_dut_nopad (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_vld(s_vld0), .s_last(s_last),
    .s_rdy(s_rdy0), .m_data(m_data0), .m_vld(m_vld0), .m_last(m_last0), .m_rdy(m_rdy0)
  );

  fcs_gen_8 #(.P_MIN_LEN(60), .P_CNT_W(6)) u_dut_pad (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_vld(s_vld1), .s_last(s_last),
    .s_rdy(s_rdy1), .m_data(m_data1), .m_vld(m_vld1), .m_last(m_last1), .m_rdy(m_rdy1)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  int         exp_len_q[$];
  logic [31:0] exp_fcs_q[$];
  logic [7:0] rx_q[$];
  int         rx_cnt = 0;
  int         frames_done = 0;
  bit         bp_en = 1'b0;
  bit         arm4 = 1'b0;
  bit         seen4 = 1'b0;
  int         arm4_target = 0;
  int         gaps = 0;
  logic [7:0] rand_buf[128];

  typedef struct {
    bit          sel;
    int          len;
    int          pat;
    bit          bp;
    int          exp_total;
    logic [31:0] exp_fcs;
    bit          lat_chk;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reflected CRC-32 (poly 0xEDB88320), the textbook LSB-first formulation.
  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] get_byte(input int pat, input int i);
    case (pat)
      PAT_ASCII: return 8'h31 + 8'(i);
      PAT_AA:    return 8'hAA;
      default:   return rand_buf[i % 128];
    endcase
  endfunction

  task automatic push_expected(input logic [7:0] f[$], input int min_len,
                               input int exp_total, input logic [31:0] exp_fcs);
    logic [7:0]  p[$];
    logic [31:0] fcs;
    p = f;
    while (p.size() < min_len) p.push_back(8'h00);
    fcs = ~ref_crc(p);
    p.push_back(fcs[7:0]);
    p.push_back(fcs[15:8]);
    p.push_back(fcs[23:16]);
    p.push_back(fcs[31:24]);
    for (int i = 0; i < p.size(); i++) begin
      exp_q.push_back({(i == p.size() - 1), p[i]});
    end
    exp_len_q.push_back((exp_total == 0) ? p.size() : exp_total);
    exp_fcs_q.push_back(exp_fcs);
  endtask

  task automatic drive_byte(input logic [7:0] d, input bit last);
    int n;
    n = 0;
    s_data = d;
    s_vld  = 1'b1;
    s_last = last;
    forever begin
      @(negedge clk);
      if (s_rdy) break;
      n++;
      if (n > 2000) break;
    end
    if (n > 2000) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no s_rdy within %0d cycles", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_len_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(exp_q.size() == 0 && exp_len_q.size() == 0, {"drain_", name},
          32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit sel_i, input int len, input int pat, input bit bp,
                           input int exp_total, input logic [31:0] exp_fcs,
                           input bit lat_chk);
    logic [7:0] f[$];
    int         busy_rdy;
    int         n;
    sel   = sel_i;
    bp_en = bp;
    if (!bp) m_rdy = 1'b1;
    for (int i = 0; i < len; i++) f.push_back(get_byte(pat, i));
    push_expected(f, sel_i ? 60 : 0, exp_total, exp_fcs);
    for (int i = 0; i < len; i++) begin
      drive_byte(f[i], i == len - 1);
      if (lat_chk && i == 0) begin
        check(m_vld == 1'b1 && m_data == f[0], "first_latency", {23'd0, m_vld, m_data},
              {24'd1, f[0]});
      end
    end
    s_vld  = 1'b0;
    s_last = 1'b0;
    busy_rdy = 0;
    n = 0;
    // Between the last accepted byte and the final FCS byte, input stays blocked.
    forever begin
      @(negedge clk);
      if (m_vld && m_last) break;
      if (s_rdy) busy_rdy++;
      n++;
      if (n > 3000) break;
    end
    check(busy_rdy == 0 && n <= 3000, "s_rdy_low_pad_fcs", 32'(busy_rdy), 32'd0);
    wait_drain("frame");
    bp_en = 1'b0;
    m_rdy = 1'b1;
  endtask

  task automatic monitor();
    logic [8:0]  e;
    bit          hold;
    logic [7:0]  hd;
    logic        hl;
    int          el;
    logic [31:0] ef;
    logic [31:0] got;
    int          n;
    hold = 1'b0;
    hd = 8'h00;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check(m_vld && m_data == hd && m_last == hl, "hold_stable",
                {23'd0, m_last, m_data}, {23'd0, hl, hd});
        end
        if (arm4) begin
          if (m_vld) seen4 = 1'b1;
          else if (seen4) gaps++;
        end
        if (m_vld && m_rdy) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_byte", {23'd0, m_last, m_data}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check({m_last, m_data} === e, "out_byte", {23'd0, m_last, m_data}, {23'd0, e});
          end
          rx_q.push_back(m_data);
          rx_cnt++;
          if (m_last) begin
            n = rx_q.size();
            if (exp_len_q.size() == 0) begin
              check(1'b0, "unexpected_frame", 32'(n), 32'd0);
            end else begin
              el = exp_len_q.pop_front();
              ef = exp_fcs_q.pop_front();
              check(n == el, "frame_len", 32'(n), 32'(el));
              if (ef != 32'd0 && n >= 4) begin
                got = {rx_q[n-1], rx_q[n-2], rx_q[n-3], rx_q[n-4]};
                check(got == ef, "fcs_value", got, ef);
              end
            end
            check(ref_crc(rx_q) == 32'hDEBB20E3, "residue", ref_crc(rx_q), 32'hDEBB20E3);
            rx_q.delete();
            rx_cnt = 0;
            frames_done++;
            if (arm4 && frames_done >= arm4_target) arm4 = 1'b0;
          end
        end
        hold = m_vld && !m_rdy;
        hd = m_data;
        hl = m_last;
      end
    end
  endtask

  task automatic bp_driver();
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) m_rdy = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic back_to_back();
    logic [7:0] f[$];
    int         lens[3];
    lens[0] = 60;
    lens[1] = 61;
    lens[2] = 1;
    sel = 1'b1;
    bp_en = 1'b0;
    m_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      f.delete();
      for (int i = 0; i < lens[k]; i++) f.push_back(rand_buf[(i + 7 * k) % 128]);
      push_expected(f, 60, (lens[k] < 60) ? 64 : lens[k] + 4, 32'd0);
    end
    gaps = 0;
    seen4 = 1'b0;
    arm4_target = frames_done + 3;
    arm4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < lens[k]; i++) begin
        drive_byte(rand_buf[(i + 7 * k) % 128], i == lens[k] - 1);
      end
    end
    s_vld = 1'b0;
    s_last = 1'b0;
    wait_drain("b2b");
    check(gaps == 0, "b2b_no_idle", 32'(gaps), 32'd0);
    check(frames_done == arm4_target, "b2b_frames", 32'(frames_done), 32'(arm4_target));
    arm4 = 1'b0;
  endtask

  task automatic reset_mid_fcs();
    int n;
    sel = 1'b0;
    m_rdy = 1'b1;
    begin
      logic [7:0] f[$];
      for (int i = 0; i < 9; i++) f.push_back(get_byte(PAT_ASCII, i));
      push_expected(f, 0, 13, 32'hCBF43926);
    end
    for (int i = 0; i < 9; i++) drive_byte(get_byte(PAT_ASCII, i), i == 8);
    s_vld = 1'b0;
    s_last = 1'b0;
    n = 0;
    // Wait until FCS byte 2 (output byte index 11) sits in the output register.
    while (!(m_vld && rx_cnt == 11) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(n < 100 && m_data == 8'hF4, "reach_fcs2", {24'd0, m_data}, 32'hF4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check(m_vld0 == 1'b0, "rst_mid_m_vld", {31'd0, m_vld0}, 32'd0);
    check(s_rdy0 == 1'b0, "rst_mid_s_rdy", {31'd0, s_rdy0}, 32'd0);
    exp_q.delete();
    exp_len_q.delete();
    exp_fcs_q.delete();
    rx_q.delete();
    rx_cnt = 0;
    run_frame(1'b0, 9, PAT_ASCII, 1'b0, 13, 32'hCBF43926, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0,   9, PAT_ASCII, 1'b0,  13, 32'hCBF43926, 1'b1};
    vecs[1] = '{1'b1,   1, PAT_AA,    1'b0,  64, 32'd0,        1'b1};
    vecs[2] = '{1'b1, 100, PAT_RAND,  1'b1, 104, 32'd0,        1'b0};
    vecs[3] = '{1'b1, 100, PAT_RAND,  1'b0, 104, 32'd0,        1'b0};
    vecs[4] = '{1'b1,  59, PAT_RAND,  1'b0,  64, 32'd0,        1'b0};
    vecs[5] = '{1'b1,  60, PAT_RAND,  1'b1,  64, 32'd0,        1'b0};
    vecs[6] = '{1'b0,   9, PAT_ASCII, 1'b1,  13, 32'hCBF43926, 1'b0};
    vecs[7] = '{1'b0,   1, PAT_AA,    1'b0,   5, 32'd0,        1'b0};

    for (int i = 0; i < 128; i++) rand_buf[i] = 8'($urandom_range(0, 255));

    fork
      monitor();
      bp_driver();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check(m_vld0 == 1'b0 && m_vld1 == 1'b0, "reset_m_vld", {30'd0, m_vld1, m_vld0}, 32'd0);
    check(m_last0 == 1'b0 && m_last1 == 1'b0, "reset_m_last", {30'd0, m_last1, m_last0}, 32'd0);
    check(m_data0 == 8'h00 && m_data1 == 8'h00, "reset_m_data", {16'd0, m_data1, m_data0}, 32'd0);
    check(s_rdy0 == 1'b0 && s_rdy1 == 1'b0, "reset_s_rdy", {30'd0, s_rdy1, s_rdy0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[v]) begin
      run_frame(vecs[v].sel, vecs[v].len, vecs[v].pat, vecs[v].bp, vecs[v].exp_total,
                vecs[v].exp_fcs, vecs[v].lat_chk);
    end

    back_to_back();
    reset_mid_fcs();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 128; i++) rand_buf[i] = 8'($urandom_range(0, 255));
      run_frame(1'($urandom_range(0, 1)), $urandom_range(1, 80), PAT_RAND,
                1'($urandom_range(0, 1)), 0, 32'd0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
